// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Branch-control / PC bus between the decode-ALU stage and the
//            program-counter sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                stall;
    logic [2:0]          br_type;
    logic                alu_zero;
    logic [PC_WIDTH-1:0] signext;
    logic [PC_WIDTH-1:0] reg_target;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] link_out;
    logic                redirect;
    logic                ras_full;
    logic                ras_empty;
    logic                ras_underflow;

    modport master (
        output stall, br_type, alu_zero, signext, reg_target,
        input  pc, link_out, redirect, ras_full, ras_empty, ras_underflow
    );

    modport slave (
        input  stall, br_type, alu_zero, signext, reg_target,
        output pc, link_out, redirect, ras_full, ras_empty, ras_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : LEGLite program counter with SEQ/CBZ/CBNZ/B/BL/BR/RET selection,
//            stall, and a circular return-address stack when PC_RAS_EN is
//            defined (single link register otherwise).
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_SHIFT = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  RAS_DEPTH   = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    pc_sequencer_if.slave bus
);
    localparam logic [PC_WIDTH-1:0] c_step = PC_WIDTH'(1) << INSTR_SHIFT;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_redirect;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_target_pc;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_link;
    logic                w_link_valid;
    logic                w_taken;
    logic                w_push;

    assign w_seq_pc    = r_pc + c_step;
    assign w_target_pc = r_pc + (bus.signext << INSTR_SHIFT);

    always_comb begin
        w_next_pc = w_seq_pc;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        case (bus.br_type)
            3'b001: if (bus.alu_zero) begin
                w_next_pc = w_target_pc;
                w_taken   = 1'b1;
            end
            3'b010: if (!bus.alu_zero) begin
                w_next_pc = w_target_pc;
                w_taken   = 1'b1;
            end
            3'b011: begin
                w_next_pc = w_target_pc;
                w_taken   = 1'b1;
            end
            3'b100: begin
                w_next_pc = w_target_pc;
                w_taken   = 1'b1;
                w_push    = 1'b1;
            end
            3'b101: begin
                w_next_pc = bus.reg_target;
                w_taken   = 1'b1;
            end
            3'b110: begin
                w_next_pc = w_link_valid ? w_link : bus.reg_target;
                w_taken   = 1'b1;
            end
            default: ;
        endcase
    end

    // A stalled cycle never requests a flush, even if the held instruction branches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
        end else if (bus.stall) begin
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_redirect <= w_taken;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.redirect = r_redirect;

`ifdef PC_RAS_EN
    localparam int                 c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_underflow;
    logic [c_ptr_w-1:0]  w_top_ptr;
    logic                w_ret;

    assign w_ret        = (bus.br_type == 3'b110);
    assign w_top_ptr    = r_wr_ptr - c_ptr_w'(1);
    assign w_link_valid = (r_count != '0);
    assign w_link       = r_ras[w_top_ptr];

    // Write pointer wraps freely so a push on a full stack overwrites the oldest entry.
    always_ff @(posedge clock) begin
        if (!reset && !bus.stall && w_push) begin
            r_ras[r_wr_ptr] <= w_seq_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (!bus.stall) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (r_count != c_full) begin
                    r_count <= r_count + c_cnt_w'(1);
                end
            end else if (w_ret) begin
                if (w_link_valid) begin
                    r_wr_ptr <= w_top_ptr;
                    r_count  <= r_count - c_cnt_w'(1);
                end else begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign bus.link_out      = w_link_valid ? w_link : '0;
    assign bus.ras_full      = (r_count == c_full);
    assign bus.ras_empty     = (r_count == '0);
    assign bus.ras_underflow = r_underflow;
`else
    localparam int c_unused_ras_depth = RAS_DEPTH;

    logic [PC_WIDTH-1:0] r_link;

    // RET reads the link register but leaves it intact for repeated returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_link <= '0;
        end else if (!bus.stall && w_push) begin
            r_link <= w_seq_pc;
        end
    end

    assign w_link            = r_link;
    assign w_link_valid      = 1'b1;
    assign bus.link_out      = r_link;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_empty     = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed and random checks of pc_sequencer against a queue-based
//            behavioural model (follows PC_RAS_EN like the design).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int          c_w     = 16;
    localparam int          c_shift = 1;
    localparam int          c_depth = 4;
    localparam logic [15:0] c_rst_pc = 16'h0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pc_sequencer_if #(.PC_WIDTH(c_w)) bus ();

    pc_sequencer #(
        .PC_WIDTH   (c_w),
        .INSTR_SHIFT(c_shift),
        .RESET_PC   (c_rst_pc),
        .RAS_DEPTH  (c_depth)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the stack is a queue, newest entry at the back.
    logic [15:0] m_pc;
    logic [15:0] m_link;
    logic        m_redirect;
    logic        m_underflow;
    logic [15:0] m_ras[$];

    task automatic model_edge();
        int unsigned isz;
        int unsigned seq;
        int unsigned tgt;
        isz = 1 << c_shift;
        if (reset) begin
            m_pc = c_rst_pc;
            m_link = 16'h0000;
            m_redirect = 1'b0;
            m_underflow = 1'b0;
            m_ras.delete();
        end else if (bus.stall) begin
            m_redirect = 1'b0;
        end else begin
            seq = (int'(m_pc) + isz) % 65536;
            tgt = (int'(m_pc) + int'(bus.signext) * isz) % 65536;
            m_redirect = 1'b1;
            case (bus.br_type)
                3'd1: if (bus.alu_zero) m_pc = 16'(tgt); else begin m_pc = 16'(seq); m_redirect = 1'b0; end
                3'd2: if (!bus.alu_zero) m_pc = 16'(tgt); else begin m_pc = 16'(seq); m_redirect = 1'b0; end
                3'd3: m_pc = 16'(tgt);
                3'd4: begin
                    m_link = 16'(seq);
                    m_ras.push_back(16'(seq));
                    if (m_ras.size() > c_depth) m_ras.delete(0);
                    m_pc = 16'(tgt);
                end
                3'd5: m_pc = bus.reg_target;
                3'd6: begin
`ifdef PC_RAS_EN
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc = bus.reg_target;
                        m_underflow = 1'b1;
                    end
`else
                    m_pc = m_link;
`endif
                end
                default: begin
                    m_pc = 16'(seq);
                    m_redirect = 1'b0;
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_link;
        logic        e_full;
        logic        e_empty;
        logic        e_uf;
`ifdef PC_RAS_EN
        e_link  = (m_ras.size() > 0) ? m_ras[$] : 16'h0000;
        e_full  = (m_ras.size() == c_depth);
        e_empty = (m_ras.size() == 0);
        e_uf    = m_underflow;
`else
        e_link  = m_link;
        e_full  = 1'b0;
        e_empty = 1'b0;
        e_uf    = 1'b0;
`endif
        check("pc", bus.pc, m_pc);
        check("link_out", bus.link_out, e_link);
        check("redirect", 16'(bus.redirect), 16'(m_redirect));
        check("ras_full", 16'(bus.ras_full), 16'(e_full));
        check("ras_empty", 16'(bus.ras_empty), 16'(e_empty));
        check("ras_underflow", 16'(bus.ras_underflow), 16'(e_uf));
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] bt,
                        input logic az, input logic [15:0] se, input logic [15:0] rt);
        reset          = rst;
        bus.stall      = st;
        bus.br_type    = bt;
        bus.alu_zero   = az;
        bus.signext    = se;
        bus.reg_target = rt;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] held_pc;
        logic [15:0] held_link;

        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        check("reset_pc", bus.pc, c_rst_pc);
        check("reset_link", bus.link_out, 16'h0000);
        repeat (3) step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        check("seq3_pc", bus.pc, 16'h0006);
        check("seq3_redirect", 16'(bus.redirect), 16'h0000);

        step(1'b0, 1'b0, 3'd5, 1'b0, 16'h0, 16'h0010);
        step(1'b0, 1'b0, 3'd1, 1'b1, 16'hFFFC, 16'h0);
        check("cbz_taken_pc", bus.pc, 16'h0008);
        check("cbz_taken_redirect", 16'(bus.redirect), 16'h0001);
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'h0, 16'h0010);
        step(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFC, 16'h0);
        check("cbz_not_taken_pc", bus.pc, 16'h0012);
        step(1'b0, 1'b0, 3'd2, 1'b1, 16'h0004, 16'h0);

        step(1'b0, 1'b0, 3'd5, 1'b0, 16'h0, 16'h0020);
        step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0010, 16'h0);
        check("bl_pc", bus.pc, 16'h0040);
        check("bl_link", bus.link_out, 16'h0022);
        step(1'b0, 1'b0, 3'd6, 1'b0, 16'h0, 16'h0);
        check("ret_pc", bus.pc, 16'h0022);

        repeat (5) step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0008, 16'h0);
        repeat (5) step(1'b0, 1'b0, 3'd6, 1'b0, 16'h0, 16'h0100);
`ifdef PC_RAS_EN
        check("ret_underflow_pc", bus.pc, 16'h0100);
        check("ret_underflow_flag", 16'(bus.ras_underflow), 16'h0001);
`endif

        held_pc   = bus.pc;
        held_link = bus.link_out;
        repeat (3) step(1'b0, 1'b1, 3'd3, 1'b0, 16'h0008, 16'h0);
        check("stall_pc_hold", bus.pc, held_pc);
        check("stall_link_hold", bus.link_out, held_link);
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0008, 16'h0);
        check("stall_release_pc", bus.pc, 16'(held_pc + 16'h0010));

        step(1'b0, 1'b0, 3'd5, 1'b0, 16'h0, 16'hFFFE);
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        check("wrap_pc", bus.pc, 16'h0000);
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'h0, 16'h1234);
        step(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 16'h1234);
        check("reset_priority_pc", bus.pc, c_rst_pc);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
